// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU control path: opcode encodings,
// ALU operation class codes, FSM state encoding and the opcode class record.
package cpu_pkg;

  // Instruction opcodes (4-bit encoding)
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_MUL   = 4'b0110;
  localparam logic [3:0] OP_LW    = 4'b1000;
  localparam logic [3:0] OP_SW    = 4'b1001;
  localparam logic [3:0] OP_BEQ   = 4'b1010;
  localparam logic [3:0] OP_BNE   = 4'b1011;

  // ALUOp class codes handed to the ALU control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_MUL   = 2'b11;

  // Main control FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6,
    ST_HALT   = 3'd7
  } state_e;

  // Opcode class flags produced by opcode_classify
  typedef struct packed {
    logic legal;
    logic is_mem;
    logic is_store;
    logic is_branch;
    logic is_bne;
    logic is_mul;
  } opclass_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle. The control unit is the master: it
// consumes instruction fields, Zero and MemReady, and drives every enable.
// Handshake: MemRead/MemWrite form a request that stays asserted while the
// FSM waits; the access completes in the cycle where the request is high and
// MemReady is high. MemReady is ignored whenever no request is asserted.
interface multicycle_control_if #(
  parameter int OPW = 4,
  parameter int FNW = 4
);
  import cpu_pkg::*;

  logic [OPW-1:0] InstrOpcode;
  logic [FNW-1:0] InstrFunct;
  logic           Zero;
  logic           MemReady;
  logic [1:0]     ALUOp;
  logic [OPW-1:0] Opcode;
  logic [FNW-1:0] Funct;
  logic           MemRead;
  logic           MemWrite;
  logic           IorD;
  logic           IRWrite;
  logic           PCWrite;
  logic           PCSrc;
  logic           ALUSrcB;
  logic           RegWrite;
  logic           RegDst;
  logic           MemToReg;
  logic           Halted;
  state_e         state_dbg;

  modport master (
    input  InstrOpcode, InstrFunct, Zero, MemReady,
    output ALUOp, Opcode, Funct, MemRead, MemWrite, IorD, IRWrite, PCWrite,
           PCSrc, ALUSrcB, RegWrite, RegDst, MemToReg, Halted, state_dbg
  );

  modport slave (
    output InstrOpcode, InstrFunct, Zero, MemReady,
    input  ALUOp, Opcode, Funct, MemRead, MemWrite, IorD, IRWrite, PCWrite,
           PCSrc, ALUSrcB, RegWrite, RegDst, MemToReg, Halted, state_dbg
  );
endinterface

// File: rtl/multicycle_control_opcode_classify.sv
// Combinational opcode decode into class flags, shared by DECODE and EXEC.
module opcode_classify
  import cpu_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output opclass_t       cls
);

  // Map each legal opcode to its class; anything else stays illegal
  always_comb begin
    cls = '0;
    case (opcode)
      OPW'(OP_RTYPE): cls.legal = 1'b1;
      OPW'(OP_MUL): begin
        cls.legal  = 1'b1;
        cls.is_mul = 1'b1;
      end
      OPW'(OP_LW): begin
        cls.legal  = 1'b1;
        cls.is_mem = 1'b1;
      end
      OPW'(OP_SW): begin
        cls.legal    = 1'b1;
        cls.is_mem   = 1'b1;
        cls.is_store = 1'b1;
      end
      OPW'(OP_BEQ): begin
        cls.legal     = 1'b1;
        cls.is_branch = 1'b1;
      end
      OPW'(OP_BNE): begin
        cls.legal     = 1'b1;
        cls.is_branch = 1'b1;
        cls.is_bne    = 1'b1;
      end
      default: cls = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle CPU: sequences fetch, decode, execute,
// memory and write-back, and holds the opcode/funct pair stable for the ALU
// control decoder from DECODE until the next DECODE.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter int OPW = 4,
  parameter int FNW = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  multicycle_control_if.master bus
);

  state_e         state_q, state_d;
  logic [OPW-1:0] opcode_q, opcode_d;
  logic [FNW-1:0] funct_q, funct_d;
  logic [OPW-1:0] cls_opcode;
  opclass_t       cls;

  logic [1:0] alu_op;
  logic       mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src;
  logic       alu_src_b, reg_write, reg_dst, mem_to_reg, halted;

  // In DECODE the fresh instruction is classified; afterwards the latched copy
  assign cls_opcode = (state_q == ST_DECODE) ? bus.InstrOpcode : opcode_q;

  opcode_classify #(.OPW(OPW)) u_classify (
    .opcode (cls_opcode),
    .cls    (cls)
  );

  // Next-state selection and opcode/funct capture
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (bus.MemReady) state_d = ST_DECODE;
      ST_DECODE: begin
        opcode_d = bus.InstrOpcode;
        funct_d  = bus.InstrFunct;
        if (!cls.legal)         state_d = ST_HALT;
        else if (cls.is_branch) state_d = ST_BRANCH;
        else                    state_d = ST_EXEC;
      end
      ST_EXEC:   state_d = cls.is_mem ? ST_MEM : ST_WB;
      ST_MEM:    if (bus.MemReady) state_d = cls.is_store ? ST_FETCH : ST_WB;
      ST_WB:     state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath enables: Moore on state, Mealy on MemReady (FETCH) and Zero (BRANCH)
  always_comb begin
    alu_op     = ALUOP_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_b  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_read = 1'b1;
        ir_write = bus.MemReady;
        pc_write = bus.MemReady;
      end
      ST_EXEC: begin
        if (cls.is_mem) begin
          alu_op    = ALUOP_ADD;
          alu_src_b = 1'b1;
        end else if (cls.is_mul) begin
          alu_op = ALUOP_MUL;
        end else begin
          alu_op = ALUOP_RTYPE;
        end
      end
      ST_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = ~cls.is_store;
        mem_write = cls.is_store;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = ~cls.is_mem;
        mem_to_reg = cls.is_mem;
      end
      ST_BRANCH: begin
        alu_op   = ALUOP_SUB;
        pc_src   = 1'b1;
        pc_write = cls.is_bne ? ~bus.Zero : bus.Zero;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // State and decoder-facing registers; reset returns to IDLE with cleared fields
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
    end
  end

  assign bus.ALUOp     = alu_op;
  assign bus.Opcode    = opcode_q;
  assign bus.Funct     = funct_q;
  assign bus.MemRead   = mem_read;
  assign bus.MemWrite  = mem_write;
  assign bus.IorD      = i_or_d;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_write;
  assign bus.PCSrc     = pc_src;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.RegWrite  = reg_write;
  assign bus.RegDst    = reg_dst;
  assign bus.MemToReg  = mem_to_reg;
  assign bus.Halted    = halted;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state sequence and checks every control output cycle by cycle.
module tb_multicycle_control;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  multicycle_control_if #(.OPW(4), .FNW(4)) bus ();

  multicycle_control #(.OPW(4), .FNW(4)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .bus     (bus.master)
  );

  // Control vector: {ALUOp, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSrc,
  //                  ALUSrcB, RegWrite, RegDst, MemToReg, Halted}
  logic [12:0] ctrl_obs;
  assign ctrl_obs = {bus.ALUOp, bus.MemRead, bus.MemWrite, bus.IorD, bus.IRWrite,
                     bus.PCWrite, bus.PCSrc, bus.ALUSrcB, bus.RegWrite, bus.RegDst,
                     bus.MemToReg, bus.Halted};

  function automatic logic [12:0] ex(input logic [1:0] aop, input logic mr, mw, iord,
                                     irw, pcw, pcs, srcb, rw, rd, m2r, h);
    return {aop, mr, mw, iord, irw, pcw, pcs, srcb, rw, rd, m2r, h};
  endfunction

  localparam logic [12:0] E_ZERO       = 13'd0;
  localparam logic [12:0] E_FETCH_WAIT = ex(2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [12:0] E_FETCH_GO   = ex(2'b00, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
  localparam logic [12:0] E_EXEC_R     = ex(2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [12:0] E_EXEC_MUL   = ex(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [12:0] E_EXEC_MEM   = ex(2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  localparam logic [12:0] E_MEM_LW     = ex(2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [12:0] E_MEM_SW     = ex(2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
  localparam logic [12:0] E_WB_R       = ex(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
  localparam logic [12:0] E_WB_LW      = ex(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
  localparam logic [12:0] E_BR_TAKE    = ex(2'b01, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
  localparam logic [12:0] E_BR_NOT     = ex(2'b01, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
  localparam logic [12:0] E_HALT       = ex(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctrl(input string tag, input logic [12:0] exp);
    #1;
    checks++;
    assert (ctrl_obs === exp) else begin
      errors++;
      $error("FAIL %s: ctrl observed=%b expected=%b", tag, ctrl_obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input state_e exp);
    checks++;
    assert (bus.state_dbg === exp) else begin
      errors++;
      $error("FAIL %s: state observed=%0d expected=%0d", tag, bus.state_dbg, exp);
    end
  endtask

  task automatic chk_opf(input string tag, input logic [3:0] exp_op, input logic [3:0] exp_fn);
    checks++;
    assert ({bus.Opcode, bus.Funct} === {exp_op, exp_fn}) else begin
      errors++;
      $error("FAIL %s: opcode/funct observed=%b/%b expected=%b/%b",
             tag, bus.Opcode, bus.Funct, exp_op, exp_fn);
    end
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [3:0] fn);
    bus.InstrOpcode = op;
    bus.InstrFunct  = fn;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus.MemReady = 1'b0;
    bus.Zero     = 1'b0;
    set_instr(4'b0000, 4'b0000);

    // Reset state
    chk_ctrl("reset_outputs", E_ZERO);
    chk_opf("reset_opf", 4'b0000, 4'b0000);
    chk_state("reset_state", ST_IDLE);
    tick();
    rst_n = 1'b1;
    chk_ctrl("idle_after_reset", E_ZERO);
    tick();
    chk_ctrl("fetch_wait_1", E_FETCH_WAIT);
    tick();
    chk_ctrl("fetch_wait_2", E_FETCH_WAIT);
    chk_state("fetch_hold", ST_FETCH);

    // Reset in the middle of a fetch drops MemRead at once
    rst_n = 1'b0;
    chk_ctrl("reset_mid_fetch", E_ZERO);
    tick();
    chk_ctrl("reset_held", E_ZERO);
    rst_n = 1'b1;
    chk_ctrl("idle_after_rerelease", E_ZERO);
    chk_state("idle_state", ST_IDLE);
    tick();
    chk_ctrl("fetch_after_idle", E_FETCH_WAIT);

    // R-format 0000/0011, zero-wait memory: 4 cycles
    bus.MemReady = 1'b1;
    set_instr(4'b0000, 4'b0011);
    chk_ctrl("r_fetch", E_FETCH_GO);
    tick();
    chk_ctrl("r_decode", E_ZERO);
    chk_state("r_decode_state", ST_DECODE);
    tick();
    chk_ctrl("r_exec", E_EXEC_R);
    chk_opf("r_exec_opf", 4'b0000, 4'b0011);
    tick();
    chk_ctrl("r_wb", E_WB_R);
    tick();
    chk_state("r_back_to_fetch", ST_FETCH);

    // LW with two wait cycles in MEM: 7 cycles
    set_instr(4'b1000, 4'b0000);
    chk_ctrl("lw_fetch", E_FETCH_GO);
    tick();
    chk_ctrl("lw_decode", E_ZERO);
    tick();
    chk_ctrl("lw_exec", E_EXEC_MEM);
    tick();
    bus.MemReady = 1'b0;
    chk_ctrl("lw_mem_wait1", E_MEM_LW);
    tick();
    chk_ctrl("lw_mem_wait2", E_MEM_LW);
    chk_state("lw_mem_hold", ST_MEM);
    tick();
    bus.MemReady = 1'b1;
    chk_ctrl("lw_mem_done", E_MEM_LW);
    tick();
    chk_ctrl("lw_wb", E_WB_LW);
    tick();
    chk_state("lw_back_to_fetch", ST_FETCH);

    // SW; instruction bus changes after DECODE but Opcode must hold
    set_instr(4'b1001, 4'b0101);
    chk_ctrl("sw_fetch", E_FETCH_GO);
    tick();
    chk_ctrl("sw_decode", E_ZERO);
    tick();
    set_instr(4'b1111, 4'b1111);
    chk_ctrl("sw_exec", E_EXEC_MEM);
    chk_opf("sw_exec_opf_stable", 4'b1001, 4'b0101);
    tick();
    chk_ctrl("sw_mem", E_MEM_SW);
    tick();
    chk_state("sw_back_to_fetch", ST_FETCH);
    chk_ctrl("sw_no_regwrite", E_FETCH_GO);

    // BEQ: PCWrite follows Zero combinationally; 3 cycles
    set_instr(4'b1010, 4'b0000);
    tick();
    chk_ctrl("beq_decode", E_ZERO);
    tick();
    bus.Zero = 1'b1;
    chk_ctrl("beq_zero1", E_BR_TAKE);
    bus.Zero = 1'b0;
    chk_ctrl("beq_zero0", E_BR_NOT);
    tick();
    chk_state("beq_back_to_fetch", ST_FETCH);

    // BNE: inverted sense on Zero
    set_instr(4'b1011, 4'b0000);
    tick();
    tick();
    bus.Zero = 1'b1;
    chk_ctrl("bne_zero1", E_BR_NOT);
    bus.Zero = 1'b0;
    chk_ctrl("bne_zero0", E_BR_TAKE);
    chk_opf("bne_opf", 4'b1011, 4'b0000);
    tick();
    chk_state("bne_back_to_fetch", ST_FETCH);

    // MUL 0110/0101
    set_instr(4'b0110, 4'b0101);
    tick();
    tick();
    chk_ctrl("mul_exec", E_EXEC_MUL);
    tick();
    chk_ctrl("mul_wb", E_WB_R);
    tick();
    chk_state("mul_back_to_fetch", ST_FETCH);

    // Illegal opcode traps into HALT, which only reset leaves
    set_instr(4'b1111, 4'b0000);
    tick();
    chk_ctrl("ill_decode", E_ZERO);
    tick();
    chk_ctrl("halt_entry", E_HALT);
    for (int i = 0; i < 20; i++) begin
      bus.MemReady = 1'($urandom_range(0, 1));
      bus.Zero     = 1'($urandom_range(0, 1));
      set_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      chk_ctrl("halt_absorb", E_HALT);
      tick();
    end
    chk_state("halt_state", ST_HALT);
    rst_n = 1'b0;
    chk_ctrl("halt_reset", E_ZERO);
    chk_opf("halt_reset_opf", 4'b0000, 4'b0000);
    tick();
    rst_n = 1'b1;
    tick();
    bus.MemReady = 1'b0;
    chk_ctrl("fetch_after_halt", E_FETCH_WAIT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: run did not complete");
    $fatal(1, "timeout");
  end

endmodule
